// File: rtl/game_pkg.sv
// Shared UART framing definitions for the game link encoder/decoder pair.
package game_pkg;

  localparam int unsigned UART_FRAME_LEN = 6;

  localparam logic [3:0] UART_TAG_HDR  = 4'd0;
  localparam logic [3:0] UART_TAG_XLO  = 4'd1;
  localparam logic [3:0] UART_TAG_XHI  = 4'd2;
  localparam logic [3:0] UART_TAG_YHI  = 4'd3;
  localparam logic [3:0] UART_TAG_YLO  = 4'd4;
  localparam logic [3:0] UART_TAG_COLL = 4'd5;

  typedef enum logic {HUNT, COLLECT} uart_dec_state_t;

  typedef struct packed {
    logic [1:0] player;
    logic [7:0] x;
    logic [7:0] y;
    logic       coll;
  } remote_frame_t;

endpackage

// File: rtl/uart_decoder.sv
// Reassembles 6-byte tagged UART frames from the RX FIFO and publishes
// remote-player fields only on a complete, well-formed frame.
module uart_decoder
  import game_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000,
  parameter int unsigned ERR_W          = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rx_empty,
  input  logic [7:0]       r_data,
  output logic             rd_uart,
  output logic [1:0]       remote_player,
  output logic [7:0]       remote_x,
  output logic [7:0]       remote_y,
  output logic             remote_collision,
  output logic             remote_present,
  output logic             frame_valid,
  output logic             frame_err,
  output logic [ERR_W-1:0] err_count
);

  localparam int unsigned TMO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  uart_dec_state_t state, state_n;
  logic [2:0]      expect_tag, expect_n;
  remote_frame_t   shadow, shadow_n;
  logic [TMO_W-1:0] tmo_cnt, tmo_n;
  logic [7:0]      byte_q;
  logic            byte_v;
  logic            fetch_c;
  logic            commit_c;
  logic            err_c;
  logic [3:0]      tag_c;
  logic [3:0]      nib_c;

  assign fetch_c = !rx_empty && !rd_uart && !byte_v;
  assign tag_c   = byte_q[3:0];
  assign nib_c   = byte_q[7:4];

  // Next-state: byte decode has priority over the inter-byte timeout.
  always_comb begin
    state_n  = state;
    expect_n = expect_tag;
    shadow_n = shadow;
    tmo_n    = tmo_cnt;
    commit_c = 1'b0;
    err_c    = 1'b0;

    if (byte_v) begin
      tmo_n = '0;
      unique case (state)
        HUNT: begin
          if (tag_c == UART_TAG_HDR && byte_q[7:6] == 2'b00) begin
            shadow_n.player = byte_q[5:4];
            expect_n        = 3'd1;
            state_n         = COLLECT;
          end else if (tag_c == UART_TAG_HDR || tag_c > UART_TAG_COLL) begin
            err_c = 1'b1;
          end
        end
        COLLECT: begin
          if (tag_c == UART_TAG_HDR && byte_q[7:6] == 2'b00) begin
            // Repeated header is tolerated; one arriving mid-frame restarts it.
            shadow_n.player = byte_q[5:4];
            err_c           = (expect_tag != 3'd1);
            expect_n        = 3'd1;
          end else if (tag_c == 4'(expect_tag)) begin
            expect_n = expect_tag + 3'd1;
            unique case (tag_c)
              UART_TAG_XLO: shadow_n.x[3:0] = nib_c;
              UART_TAG_XHI: shadow_n.x[7:4] = nib_c;
              UART_TAG_YHI: shadow_n.y[7:4] = nib_c;
              UART_TAG_YLO: shadow_n.y[3:0] = nib_c;
              default: begin
                state_n = HUNT;
                if (byte_q[7:5] == 3'b000) begin
                  shadow_n.coll = byte_q[4];
                  commit_c      = 1'b1;
                end else begin
                  err_c = 1'b1;
                end
              end
            endcase
          end else begin
            err_c   = 1'b1;
            state_n = HUNT;
          end
        end
        default: state_n = HUNT;
      endcase
    end else if (state == COLLECT) begin
      if (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1)) begin
        err_c   = 1'b1;
        state_n = HUNT;
        tmo_n   = '0;
      end else begin
        tmo_n = tmo_cnt + TMO_W'(1);
      end
    end else begin
      tmo_n = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= HUNT;
      expect_tag       <= '0;
      shadow           <= '0;
      tmo_cnt          <= '0;
      byte_q           <= '0;
      byte_v           <= 1'b0;
      rd_uart          <= 1'b0;
      remote_player    <= '0;
      remote_x         <= '0;
      remote_y         <= '0;
      remote_collision <= 1'b0;
      remote_present   <= 1'b0;
      frame_valid      <= 1'b0;
      frame_err        <= 1'b0;
      err_count        <= '0;
    end else begin
      state       <= state_n;
      expect_tag  <= expect_n;
      shadow      <= shadow_n;
      tmo_cnt     <= tmo_n;
      rd_uart     <= fetch_c;
      byte_v      <= fetch_c;
      frame_valid <= commit_c;
      frame_err   <= err_c;
      if (fetch_c) begin
        byte_q <= r_data;
      end
      if (commit_c) begin
        remote_player    <= shadow_n.player;
        remote_x         <= shadow_n.x;
        remote_y         <= shadow_n.y;
        remote_collision <= shadow_n.coll;
        remote_present   <= shadow_n.player[0];
      end
      if (err_c && err_count != '1) begin
        err_count <= err_count + ERR_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_uart_decoder.sv
// Scoreboard bench for uart_decoder: a FIFO model feeds bytes, a monitor
// pops expected commit/error events whenever the DUT pulses an output.
module tb_uart_decoder;
  import game_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_empty;
  logic [7:0] r_data;
  logic       rd_uart;
  logic [1:0] remote_player;
  logic [7:0] remote_x;
  logic [7:0] remote_y;
  logic       remote_collision;
  logic       remote_present;
  logic       frame_valid;
  logic       frame_err;
  logic [7:0] err_count;

  uart_decoder #(.TIMEOUT_CYCLES(16), .ERR_W(8)) dut (
    .clk(clk), .rst(rst), .rx_empty(rx_empty), .r_data(r_data), .rd_uart(rd_uart),
    .remote_player(remote_player), .remote_x(remote_x), .remote_y(remote_y),
    .remote_collision(remote_collision), .remote_present(remote_present),
    .frame_valid(frame_valid), .frame_err(frame_err), .err_count(err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         is_err;
    logic [1:0] p;
    logic [7:0] x;
    logic [7:0] y;
    logic       c;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] fifo_q[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  bit         watch_5a = 1'b0;

  localparam logic [47:0] FRAME1 = 48'h10_A1_52_33_C4_15;
  localparam logic [47:0] FRAME2 = 48'h30_01_F2_03_04_05;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  task automatic send(input int n, input logic [47:0] bytes);
    for (int i = 0; i < n; i++) fifo_q.push_back(bytes[8*(n-1-i) +: 8]);
  endtask

  task automatic exp_commit(input logic [1:0] p, input logic [7:0] x, input logic [7:0] y,
                            input logic c);
    exp_t e;
    e.is_err = 1'b0; e.p = p; e.x = x; e.y = y; e.c = c;
    exp_q.push_back(e);
  endtask

  task automatic exp_error();
    exp_t e;
    e.is_err = 1'b1; e.p = '0; e.x = '0; e.y = '0; e.c = 1'b0;
    exp_q.push_back(e);
  endtask

  // Wait for the FIFO model to empty, then let the pipeline settle.
  task automatic drain();
    int t = 0;
    while (fifo_q.size() != 0 && t < 400) begin
      @(negedge clk);
      t++;
    end
    if (t >= 400) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout: got %0d bytes left required 0", fifo_q.size());
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_player"},  32'(remote_player), 0);
    chk({tag, "_x"},       32'(remote_x), 0);
    chk({tag, "_y"},       32'(remote_y), 0);
    chk({tag, "_coll"},    32'(remote_collision), 0);
    chk({tag, "_present"}, 32'(remote_present), 0);
    chk({tag, "_errcnt"},  32'(err_count), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    fifo_q.delete();
    repeat (2) @(negedge clk);
    check_zero("in_reset");
    chk("in_reset_fv", 32'(frame_valid), 0);
    chk("in_reset_fe", 32'(frame_err), 0);
    chk("in_reset_rd", 32'(rd_uart), 0);
    rst = 1'b0;
  endtask

  // RX FIFO model: first-word-fall-through, popped by rd_uart.
  initial begin
    rx_empty = 1'b1;
    r_data   = 8'h00;
    forever begin
      @(negedge clk);
      if (rd_uart === 1'b1 && rst === 1'b0 && fifo_q.size() > 0) void'(fifo_q.pop_front());
      rx_empty = (fifo_q.size() == 0);
      r_data   = (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
    end
  end

  // Monitor: every output pulse must match the next expected event.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst === 1'b0) begin
        if (frame_valid === 1'b1 || frame_err === 1'b1) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_event", {30'd0, frame_valid, frame_err}, 0);
          end else begin
            e = exp_q.pop_front();
            if (e.is_err) begin
              chk("evt_err", {30'd0, frame_valid, frame_err}, 32'b01);
            end else begin
              chk("evt_commit", {30'd0, frame_valid, frame_err}, 32'b10);
              chk("commit_player",  32'(remote_player), 32'(e.p));
              chk("commit_x",       32'(remote_x), 32'(e.x));
              chk("commit_y",       32'(remote_y), 32'(e.y));
              chk("commit_coll",    32'(remote_collision), 32'(e.c));
              chk("commit_present", 32'(remote_present), 32'(e.p[0]));
            end
          end
        end
        if (watch_5a) chk("x_leak_5a", 32'(remote_x == 8'h5A), 0);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_zero("reset");
    chk("reset_fv", 32'(frame_valid), 0);
    chk("reset_fe", 32'(frame_err), 0);
    chk("reset_rd", 32'(rd_uart), 0);
    rst = 1'b0;

    // Clean frame with player 01.
    exp_commit(2'b01, 8'h5A, 8'h3C, 1'b1);
    send(6, FRAME1);
    drain();
    chk("t1_errcnt", 32'(err_count), 0);
    chk("t1_present", 32'(remote_present), 1);

    // Player 11 frame, trailing zero headers, then a truncated frame
    // interrupted by a fresh header.
    exp_commit(2'b11, 8'hF0, 8'h00, 1'b0);
    send(6, FRAME2);
    drain();
    chk("t2_x", 32'(remote_x), 32'h F0);
    exp_error();
    exp_commit(2'b11, 8'hF0, 8'h00, 1'b0);
    watch_5a = 1'b1;
    send(3, 48'h00_00_00);
    send(3, 48'h10_A1_52);
    send(6, FRAME2);
    drain();
    watch_5a = 1'b0;
    chk("t3_errcnt", 32'(err_count), 1);

    // Orphan body bytes in HUNT are dropped silently.
    exp_commit(2'b01, 8'h5A, 8'h3C, 1'b1);
    send(3, 48'h52_33_C4);
    send(6, FRAME1);
    drain();
    chk("t4_errcnt", 32'(err_count), 1);

    // Inter-byte timeout aborts the frame; late byte is ignored.
    do_reset();
    exp_error();
    send(3, 48'h10_A1_52);
    drain();
    repeat (20) @(negedge clk);
    send(1, 48'h33);
    drain();
    chk("t5_player",  32'(remote_player), 0);
    chk("t5_x",       32'(remote_x), 0);
    chk("t5_y",       32'(remote_y), 0);
    chk("t5_present", 32'(remote_present), 0);
    chk("t5_errcnt",  32'(err_count), 1);

    // Reset mid-frame, recovery, then a tag5 byte with a reserved bit set.
    exp_commit(2'b01, 8'h5A, 8'h3C, 1'b1);
    send(6, FRAME1);
    drain();
    send(2, 48'h10_A1);
    drain();
    do_reset();
    check_zero("t6_after_rst");
    exp_commit(2'b11, 8'hF0, 8'h00, 1'b0);
    send(6, FRAME2);
    drain();
    exp_error();
    send(6, 48'h10_A1_52_33_C4_35);
    drain();
    chk("t6_x_held",   32'(remote_x), 32'hF0);
    chk("t6_y_held",   32'(remote_y), 32'h00);
    chk("t6_errcnt",   32'(err_count), 1);

    chk("sb_empty", 32'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_decoder.md
Name: uart_decoder

Overview:
Receive-side counterpart of the game's UART frame encoder. Pops bytes from the UART RX FIFO and reassembles the 6-byte tagged frame. Each byte carries tag = byte[3:0] (0..5), payload in the upper bits. Decoded remote-player fields (player id, x, y, collision) are published to game logic only when a complete, well-formed frame has been received; partial frames never leak to the outputs.

Parameters:
TIMEOUT_CYCLES, 1_000_000, max idle clk cycles between bytes inside a frame before abort
ERR_W, 8, width of saturating error counter

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
rx_empty  in  1  RX FIFO empty; r_data valid when 0 (first-word-fall-through)
r_data  in  8  RX FIFO head byte
rd_uart  out  1  single-cycle pop strobe to RX FIFO
remote_player  out  2  selected_player field of last committed frame
remote_x  out  8  committed x coordinate
remote_y  out  8  committed y coordinate
remote_collision  out  1  committed collision flag
remote_present  out  1  1 when remote_player is 2'b01 or 2'b11
frame_valid  out  1  1-cycle pulse on commit
frame_err  out  1  1-cycle pulse on any counted protocol error
err_count  out  ERR_W  saturating count of frame_err pulses

Behaviour:
- Clock/reset: one clock, clk; rst synchronous, active-high. All outputs, FSM, staging and timeout registers clear to 0; state = HUNT.
- Frame layout: tag0 {00, player[1:0], 0000}; tag1 {x[3:0], 0001}; tag2 {x[7:4], 0010}; tag3 {y[7:4], 0011}; tag4 {y[3:0], 0100}; tag5 {000, coll, 0101}.
- Fetch stage:
  - If rx_empty==0 and rd_uart==0 and not byte_v: capture byte_q<=r_data, set byte_v=1, rd_uart<=1 next cycle.
  - rd_uart is never high two consecutive cycles, giving a max rate of 1 byte per 2 cycles.
- Process stage: byte_v consumed in the cycle after capture; state and staging update on the following edge.
- FSM uses states HUNT and COLLECT, plus expect[2:0] (1..5).
  - HUNT: tag0 with byte[7:6]==0 → stage player, COLLECT, expect=1. Any other tag 1..5 is dropped silently (no error). Tag 6..15 or tag0 with nonzero [7:6] → frame_err.
  - COLLECT, tag==expect: stage the nibble/bit into shadow registers; expect++.
  - COLLECT, tag5 accepted with byte[7:5]==0: commit all shadow fields to outputs atomically, frame_valid=1 for one cycle, go to HUNT.
  - COLLECT, tag0 with expect==1 (repeated header): restage player, no error. This tolerates the encoder's trailing 0x00 bytes.
  - COLLECT, tag0 with expect>1: frame_err; restart with the new header (expect=1).
  - COLLECT, any other mismatch, tag>5, or reserved bits nonzero: frame_err, go to HUNT, discard shadow.
- Timeout: counter runs only in COLLECT and clears on every processed byte. Reaching TIMEOUT_CYCLES-1 → frame_err, go to HUNT. Timeout and a byte in the same cycle: the byte wins.
- Latency: r_data of the tag5 byte present at cycle N (rx_empty=0) → frame_valid high in cycle N+2.
- err_count increments on each frame_err and saturates at all-ones.
- Commits with player 00/10 still update the outputs; remote_present=0 in that case.
- rst mid-frame: abandons the frame; outputs cleared; a pending byte_q is discarded. The FIFO byte popped by a same-cycle rd_uart is lost.

Decomposition:
- game_pkg gets: UART_FRAME_LEN=6, UART_TAG_HDR..UART_TAG_COLL (0..5), and typedef enum logic {HUNT, COLLECT} uart_dec_state_t, shared with the encoder.
- Single module; no sub-module is warranted.

Test Plan:
1. Bytes 10,A1,52,33,C4,15 → remote_player=01, x=5A, y=3C, collision=1, present=1; one frame_valid; err_count=0.
2. Bytes 30,01,F2,03,04,05 → player=11, x=F0, y=00, collision=0; bytes then 00,00,00 → no frame_err, outputs unchanged.
3. Bytes 10,A1,52 then the full frame from (2) → frame_err once, err_count=1. The (2) values are committed; 5A is never visible on remote_x.
4. Bytes 52,33,C4 in HUNT → no frame_err, no frame_valid; the frame from (1) that follows decodes correctly.
5. TIMEOUT_CYCLES=16: bytes 10,A1,52, then 20 idle cycles → frame_err. A late 33 is dropped silently; outputs hold their reset values.
6. Full frame, then rst asserted mid-second-frame → all outputs 0. The next full frame decodes. A final frame ending in 35 (reserved bit set) → frame_err, no commit.
